// File: rtl/wimax_pingpong_interleaver.sv
// 802.16 OFDM block interleaver with a two-bank ping-pong bit store.
// Bits are written to their permuted address and drained in natural order.
module wimax_pingpong_interleaver #(
  parameter int unsigned N_SUB     = 96,
  parameter int unsigned D         = 16,
  parameter int unsigned NCBPS_MAX = 6 * N_SUB,
  parameter int unsigned ADDR_W    = $clog2(NCBPS_MAX)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic [1:0]        out_mode,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_QAM64 = 2'd3
  } mod_e;

  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(D - 1);

  function automatic logic [ADDR_W-1:0] ncbps_of(input logic [1:0] md);
    case (mod_e'(md))
      MODE_BPSK:  return ADDR_W'(N_SUB);
      MODE_QPSK:  return ADDR_W'(2 * N_SUB);
      MODE_QAM16: return ADDR_W'(4 * N_SUB);
      default:    return ADDR_W'(6 * N_SUB);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] rows_of(input logic [1:0] md);
    case (mod_e'(md))
      MODE_BPSK:  return ADDR_W'(N_SUB / D);
      MODE_QPSK:  return ADDR_W'(2 * N_SUB / D);
      MODE_QAM16: return ADDR_W'(4 * N_SUB / D);
      default:    return ADDR_W'(6 * N_SUB / D);
    endcase
  endfunction

  function automatic logic [1:0] s_of(input logic [1:0] md);
    case (mod_e'(md))
      MODE_QAM16: return 2'd2;
      MODE_QAM64: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

  function automatic logic [1:0] rows_mod_of(input logic [1:0] md);
    case (mod_e'(md))
      MODE_QAM16: return 2'((4 * N_SUB / D) % 2);
      MODE_QAM64: return 2'((6 * N_SUB / D) % 3);
      default:    return 2'd0;
    endcase
  endfunction

  // (a + b) mod s for a, b < s <= 3
  function automatic logic [1:0] add_mod(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] s);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= {1'b0, s}) ? 2'(sum - {1'b0, s}) : sum[1:0];
  endfunction

  logic                 wr_sel, rd_sel;
  logic [1:0]           full;
  logic [1:0]           bank_mode [2];
  logic [NCBPS_MAX-1:0] mem [2];
  logic [ADDR_W-1:0]    wr_k, col, row, m_q, rd_addr;
  logic [1:0]           col_mod, row_mod, m_mod;

  logic [1:0]           w_mode, w_s, w_rows_mod, diff_mod;
  logic [ADDR_W-1:0]    w_ncbps, w_rows, wr_j;
  logic                 w_last, wr_fire, rd_fire;
  logic [ADDR_W-1:0]    col_n, row_n, m_n;
  logic [1:0]           col_mod_n, row_mod_n, m_mod_n;

  assign in_ready = !full[wr_sel];
  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;

  always_comb begin
    w_mode     = (wr_k == '0) ? mode : bank_mode[wr_sel];
    w_ncbps    = ncbps_of(w_mode);
    w_rows     = rows_of(w_mode);
    w_s        = s_of(w_mode);
    w_rows_mod = rows_mod_of(w_mode);
    w_last     = (wr_k == w_ncbps - ONE);

    // m = rows*col + row, so floor(D*m/Ncbps) is just col, and Ncbps is a
    // multiple of s; j reduces to m - (m mod s) + ((m - col) mod s).
    diff_mod = (m_mod >= col_mod) ? m_mod - col_mod : m_mod + w_s - col_mod;
    wr_j     = m_q - ADDR_W'(m_mod) + ADDR_W'(diff_mod);

    col_n     = col + ONE;
    col_mod_n = add_mod(col_mod, 2'd1, w_s);
    row_n     = row;
    row_mod_n = row_mod;
    m_n       = m_q + w_rows;
    m_mod_n   = add_mod(m_mod, w_rows_mod, w_s);
    if (col == COL_LAST) begin
      col_n     = '0;
      col_mod_n = '0;
      row_n     = row + ONE;
      row_mod_n = add_mod(row_mod, 2'd1, w_s);
      m_n       = row + ONE;
      m_mod_n   = row_mod_n;
    end
    if (w_last) begin
      col_n     = '0;
      col_mod_n = '0;
      row_n     = '0;
      row_mod_n = '0;
      m_n       = '0;
      m_mod_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      full         <= '0;
      bank_mode[0] <= '0;
      bank_mode[1] <= '0;
      wr_k         <= '0;
      col          <= '0;
      row          <= '0;
      m_q          <= '0;
      col_mod      <= '0;
      row_mod      <= '0;
      m_mod        <= '0;
      rd_addr      <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_k == '0) bank_mode[wr_sel] <= mode;
        wr_k    <= w_last ? '0 : wr_k + ONE;
        col     <= col_n;
        row     <= row_n;
        m_q     <= m_n;
        col_mod <= col_mod_n;
        row_mod <= row_mod_n;
        m_mod   <= m_mod_n;
        if (w_last) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (rd_fire) begin
        if (out_last) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
          rd_addr      <= '0;
        end else begin
          rd_addr <= rd_addr + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_sel][wr_j] <= in_data;
  end

  always_comb begin
    out_valid = full[rd_sel];
    out_mode  = bank_mode[rd_sel];
    out_index = rd_addr;
    out_data  = mem[rd_sel][rd_addr];
    out_last  = out_valid && (rd_addr == ncbps_of(out_mode) - ONE);
  end

endmodule

// File: tb/tb_wimax_pingpong_interleaver.sv
// Directed bench for wimax_pingpong_interleaver with a formula-based scoreboard.
module tb_wimax_pingpong_interleaver;

  localparam int N_SUB = 96;
  localparam int D     = 16;
  localparam int NMAX  = 6 * N_SUB;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_data = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic [1:0]    out_mode;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  wimax_pingpong_interleaver #(.N_SUB(N_SUB), .D(D), .NCBPS_MAX(NMAX), .ADDR_W(AW)) dut (
    .clk(clk), .resetN(resetN), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_mode(out_mode), .out_ready(out_ready)
  );

  int checks = 0;
  int failures = 0;
  logic [2:0]  in_q [$];
  logic [13:0] exp_q [$];
  int beats, ones, one_idx, lasts, last_idx, accepted;
  logic ready_pre, ready_post, seen_last, post_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ncpc(input int md);
    case (md)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int perm(input int md, input int k);
    int ncbps, s, m;
    ncbps = N_SUB * ncpc(md);
    s = (ncpc(md) / 2 > 1) ? ncpc(md) / 2 : 1;
    m = (ncbps / D) * (k % D) + k / D;
    return s * (m / s) + ((m + ncbps - (D * m) / ncbps) % s);
  endfunction

  function automatic logic [NMAX-1:0] rand_bits();
    logic [NMAX-1:0] b;
    for (int i = 0; i < NMAX; i++) b[i] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // Queue one block's input bits; mode input switches to alt_md from k=alt_at on.
  task automatic push_block(input int md, input int alt_at, input int alt_md,
                            input logic [NMAX-1:0] bits);
    int n;
    logic [NMAX-1:0] ob;
    n  = N_SUB * ncpc(md);
    ob = '0;
    for (int k = 0; k < n; k++) begin
      in_q.push_back({(k >= alt_at) ? 2'(alt_md) : 2'(md), bits[k]});
      ob[perm(md, k)] = bits[k];
    end
    for (int j = 0; j < n; j++) exp_q.push_back({2'(md), (j == n - 1), 10'(j), ob[j]});
  endtask

  task automatic clr_stats();
    beats = 0; ones = 0; one_idx = -1; lasts = 0; last_idx = -1; accepted = 0;
  endtask

  // Clocks both queues for at most max_cycles; called at posedge+1.
  task automatic run(input int max_cycles, input logic rdy);
    logic pop_in, pop_out;
    logic [13:0] exp;
    seen_last = 1'b0; post_done = 1'b0; ready_pre = 1'b0; ready_post = 1'b0;
    for (int c = 0; c < max_cycles && (in_q.size() > 0 || exp_q.size() > 0); c++) begin
      in_valid = (in_q.size() > 0);
      {mode, in_data} = in_valid ? in_q[0] : 3'b000;
      out_ready = rdy;
      #1;
      pop_in  = in_valid && in_ready;
      pop_out = out_valid && rdy;
      if (!seen_last) ready_pre = ready_pre | in_ready;
      else if (!post_done) begin ready_post = in_ready; post_done = 1'b1; end
      if (pop_out) begin
        exp = '1;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("beat{mode,last,index,data}", {out_mode, out_last, out_index, out_data}, exp);
        beats++;
        if (out_data) begin ones++; one_idx = out_index; end
        if (out_last) begin lasts++; last_idx = out_index; seen_last = 1'b1; end
      end
      @(posedge clk);
      #1;
      if (pop_in) begin void'(in_q.pop_front()); accepted++; end
    end
    in_valid = 1'b0;
  endtask

  task automatic single_one(input int md, input int k, input int exp_j);
    logic [NMAX-1:0] b;
    int n;
    n = N_SUB * ncpc(md);
    b = '0;
    b[k] = 1'b1;
    clr_stats();
    push_block(md, 9999, 0, b);
    run(3 * n, 1'b1);
    check("single_done", in_q.size() + exp_q.size(), 0);
    check("single_beats", beats, n);
    check("single_ones", ones, 1);
    check("single_index", one_idx, exp_j);
    check("single_last_idx", last_idx, n - 1);
  endtask

  initial begin
    logic [NMAX-1:0] b;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_mode", out_mode, 0);
    @(negedge clk) resetN = 1'b1;
    @(posedge clk);
    #1;

    // QPSK, single 1 at k=1 -> j=12; first out_valid one cycle after last input
    b = '0;
    b[1] = 1'b1;
    clr_stats();
    push_block(1, 9999, 0, b);
    run(191, 1'b1);
    check("qpsk_no_early_valid", out_valid, 0);
    check("qpsk_inputs_left", in_q.size(), 1);
    run(1, 1'b1);
    check("qpsk_first_valid", out_valid, 1);
    run(400, 1'b1);
    check("qpsk_done", in_q.size() + exp_q.size(), 0);
    check("qpsk_beats", beats, 192);
    check("qpsk_ones", ones, 1);
    check("qpsk_one_index", one_idx, 12);
    check("qpsk_lasts", lasts, 1);
    check("qpsk_last_idx", last_idx, 191);

    // Single-bit positions in the other modes
    single_one(2, 1, 25);
    single_one(3, 1, 38);
    single_one(0, 17, 7);

    // Random full blocks, all modes back to back
    clr_stats();
    for (int md = 0; md < 4; md++) push_block(md, 9999, 0, rand_bits());
    run(3000, 1'b1);
    check("all_modes_done", in_q.size() + exp_q.size(), 0);
    check("all_modes_beats", beats, 96 + 192 + 384 + 576);
    check("all_modes_lasts", lasts, 4);

    // Backpressure: both banks fill, then release
    clr_stats();
    for (int i = 0; i < 3; i++) push_block(1, 9999, 0, rand_bits());
    run(400, 1'b0);
    check("bp_accepted", accepted, 384);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_mode", out_mode, 1);
    run(2000, 1'b1);
    check("bp_ready_before_last", ready_pre, 0);
    check("bp_ready_after_last", ready_post, 1);
    check("bp_done", in_q.size() + exp_q.size(), 0);
    check("bp_beats", beats, 576);

    // Mode change mid-block ignored; then a 16QAM block right behind it
    clr_stats();
    push_block(1, 50, 3, rand_bits());
    push_block(2, 9999, 0, rand_bits());
    run(1500, 1'b1);
    check("modechg_done", in_q.size() + exp_q.size(), 0);
    check("modechg_beats", beats, 192 + 384);
    check("modechg_lasts", lasts, 2);
    check("modechg_last_idx", last_idx, 383);

    // Reset with a block mid-drain and another mid-fill
    clr_stats();
    push_block(1, 9999, 0, rand_bits());
    push_block(3, 9999, 0, rand_bits());
    run(292, 1'b1);
    check("prerst_out_valid", out_valid, 1);
    check("prerst_out_index", out_index, 100);
    resetN = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_index", out_index, 0);
    check("midrst_out_mode", out_mode, 0);
    in_q.delete();
    exp_q.delete();
    @(negedge clk) resetN = 1'b1;
    @(posedge clk);
    #1;
    clr_stats();
    push_block(2, 9999, 0, rand_bits());
    run(1000, 1'b1);
    check("postrst_done", in_q.size() + exp_q.size(), 0);
    check("postrst_beats", beats, 384);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wimax_pingpong_interleaver.md
Name: wimax_pingpong_interleaver

Overview:
- Multi-mode 802.16 OFDM block interleaver; sits between the FEC encoder and the modulator/mapper.
- Accepts a serial coded-bit stream in natural order, one bit per handshake.
- Writes each bit to its permuted address in one bank of a two-bank (ping-pong) bit memory.
- Drains completed blocks in sequential order to the mapper, so one block fills while the previous one drains.
- Modulation (BPSK/QPSK/16QAM/64QAM) is selected per block at run time.

Parameters:
- N_SUB, 96, data subcarriers per symbol; Ncbps = N_SUB*Ncpc.
- D, 16, interleaver column count d.
- NCBPS_MAX, 6*N_SUB, bank depth in bits (64QAM block size).
- ADDR_W, $clog2(NCBPS_MAX), address/index width.

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- mode  in  2  0=BPSK(Ncpc=1), 1=QPSK(2), 2=16QAM(4), 3=64QAM(6)
- in_valid  in  1  FEC bit valid
- in_data  in  1  FEC coded bit
- in_ready  out  1  interleaver can accept a bit
- out_valid  out  1  interleaved bit valid
- out_data  out  1  interleaved bit
- out_index  out  ADDR_W  output position j of out_data within its block
- out_last  out  1  high with the final bit of a block (j = Ncbps-1)
- out_mode  out  2  mode of the block being drained
- out_ready  in  1  mapper accepts the bit

Behaviour:
- Reset and clock: resetN asynchronous, active-low; clock clk.
- Reset values:
  - both banks empty, wr_sel=0, rd_sel=0, write counter k=0, read counter=0;
  - in_ready=1, out_valid=0, out_index=0, out_last=0, out_mode=0.
  - Memory contents are don't-care.
  - Reset mid-block discards all partial and full blocks.
- Derived per-mode values:
  - s = max(Ncpc/2, 1).
  - Ncbps: 96 / 192 / 384 / 576 at default N_SUB.
- Permutation for input index k (0..Ncbps-1):
  - m = (Ncbps/D)*(k mod D) + floor(k/D).
  - j = s*floor(m/s) + ((m + Ncbps - floor(D*m/Ncbps)) mod s).
  - Combinational dividers are not required; incremental counters (column/row stepping, mod-s tracking) are allowed. j must match the formula bit-exactly for every mode.
- Write side:
  - in_ready = !full[wr_sel].
  - Transfer occurs when in_valid && in_ready: bank[wr_sel][j(k)] <= in_data, then k increments.
  - mode is sampled into the write bank's mode register on the transfer with k==0. Mode changes mid-block are ignored until the next block.
  - On the transfer with k==Ncbps-1: full[wr_sel] <= 1, wr_sel toggles, k <= 0.
- Read side:
  - out_valid = full[rd_sel].
  - out_data = bank[rd_sel][rd_addr]; out_index = rd_addr; out_mode = bank mode.
  - out_last = out_valid && rd_addr == Ncbps(bank mode)-1.
  - Transfer occurs when out_valid && out_ready: rd_addr increments.
  - On the out_last transfer: full[rd_sel] <= 0, rd_sel toggles, rd_addr <= 0.
  - Outputs are held stable while out_valid && !out_ready.
- Latency and throughput:
  - First output bit of a block is valid on the cycle after the last input bit of that block is accepted.
  - Steady-state throughput is 1 bit/clk in and out.
- Boundary conditions:
  - Both banks full: in_ready=0 until the read side releases a bank. in_ready rises the cycle after the out_last transfer.
  - Simultaneous write-complete of bank A and read-complete of bank B in the same cycle are both honoured; no bit is lost or duplicated.
  - A bank is never written while full, and never read while not full.
  - Consecutive blocks may use different modes; each bank drains with its own mode and Ncbps.
  - Counters wrap only at Ncbps of the active mode, never at 2^ADDR_W.

Test Plan:
- QPSK block, input bit k=1 high, all others 0, out_ready=1 -> exactly one 1 observed, at out_index=12; 192 outputs; out_last at index 191; out_valid first high 1 cycle after 192nd input.
- 16QAM, single 1 at k=1 -> output at index 25. 64QAM, single 1 at k=1 -> index 38. BPSK, single 1 at k=17 -> index 7.
- Full-pattern check for all four modes against a reference model of the formula -> every k maps to a unique j, permutation bijective.
- out_ready=0, continuous in_valid in QPSK -> in_ready drops after exactly 384 accepted bits; release out_ready -> in_ready returns the cycle after the first out_last.
- mode changed QPSK->64QAM at k=50, and a back-to-back QPSK then 16QAM block -> first block remains 192 bits with out_mode=1; second block 384 bits with out_mode=2.
- resetN pulsed low at k=100 of a block, with a full block mid-drain -> out_valid=0 and in_ready=1 immediately; the next block starts at k=0 with correct mapping.
